mont_const_unit: RTL and testbench
==================================

// Module: mont_const_unit
// PURPOSE
// - Upstream precompute stage for rsa_unit: derives the Montgomery conversion constant
//   Const = 2^(2*K) mod M, with K = WIDTH+2 (the mmm_unit operand width), from the modulus M.
// - Bit-serial: one modular doubling per cycle, so no multiplier or divider is needed.
// - Result is held in a register with a valid flag and feeds the Const input of rsa_unit directly.
// PARAMETERS
// - WIDTH  8  width of the modulus M and of the Const result; K = WIDTH+2 is derived internally.
// PORTS
// - clk    in   1      clock; everything is clocked on the rising edge.
// - rst    in   1      reset, synchronous, active-high.
// - ena    in   1      clock enable; when low, all state and outputs hold (rst still wins).
// - clear  in   1      synchronous abort: back to IDLE, valid<=0, Const<=0, err<=0.
// - start  in   1      request; sampled only in IDLE with ena=1; M is captured on that same edge.
// - M      in   WIDTH  modulus.
// - Const  out  WIDTH  2^(2K) mod M; meaningful only while valid=1.
// - busy   out  1      high in INIT, ITER and DONE.
// - done   out  1      one-cycle pulse when a result (or an error) is posted.
// - valid  out  1      Const holds a good result; cleared by a new start, by clear, or by rst.
// - err    out  1      last request rejected (M even or zero); held until next start/clear/rst.
// BEHAVIOUR
// - Reset values: Const=0, busy=0, done=0, valid=0, err=0; state=IDLE; internal r=0, cnt=0, m_q=0.
// - Priority each edge: rst > clear > ena=0 (hold) > FSM.
// - IDLE: start=1 -> latch m_q<=M, valid<=0, err<=0; go to INIT. Otherwise stay.
// - INIT: if m_q[0]==0 (even, includes 0) -> err<=1, go to DONE.
//   Else r<=(m_q==1)?0:1, cnt<=0, go to ITER.
// - ITER, once per cycle: t = {r,1'b0} (WIDTH+1 bits);
//   r <= (t >= m_q) ? t - m_q : t; cnt <= cnt+1.
//   Leave for DONE after the iteration with cnt==2K-1, i.e. exactly 2K doublings.
// - Invariant: r < m_q always holds, so a single conditional subtract suffices.
//   Compare and subtract are done at WIDTH+1 bits, so there is no overflow.
// - DONE (one cycle): done=1.
//   No error: Const<=r[WIDTH-1:0] and valid<=1.
//   Error: Const<=0 and valid stays 0.
//   Next state is IDLE.
// - Latency, start edge to done high:
//   good path = 2K+2 cycles (22 for WIDTH=8); error path = 2 cycles.
//   valid and Const update on the same edge on which done rises.
// - start while busy is ignored: it is not queued, and M changes mid-run have no effect.
// - start in the cycle right after DONE (state IDLE) is accepted normally, so back-to-back runs work.
// - clear or rst mid-run: abort immediately with no done pulse; the next start restarts from INIT.
// - ena low mid-ITER: cnt and r freeze; latency stretches by the number of stalled cycles.
// - cnt is sized clog2(2K) bits; it must not wrap before the exit compare.
// STRUCTURE
// - rsa_pkg (shared): typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} const_state_t;
//   function mmm_width(WIDTH) returning WIDTH+2, reused by rsa_unit instances.
// - One sub-module: mod_double_unit #(WIDTH), combinational r_out = 2*r_in mod m (precondition r_in < m).
// - The top level holds the FSM, the counter, and the m_q / r / Const registers.
// TESTING (WIDTH=8, K=10, so the result is 2^20 mod M)
// - M=251, start pulse -> done exactly 22 cycles later, Const=149, valid=1, err=0.
// - M=255 -> Const=16; M=3 -> Const=1; M=1 -> Const=0; each with valid=1 and 22-cycle latency.
// - M=0, then M=254 -> done 2 cycles after start, err=1, valid=0, Const=0.
// - Run with M=251; pulse start with M=3 at cycle 5 -> ignored, result still 149.
//   start the cycle after done -> second run returns the new M's result.
// - Run with M=251; clear at cycle 10 -> no done, busy=0, valid=0.
//   ena low for 7 cycles mid-run -> done at 29 cycles, Const=149.
// - Random odd M in 1..255 vs reference model pow(2,20)%M; assert busy==(state!=IDLE), done one-hot pulse.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: precompute FSM states and the
// Montgomery operand width used by mmm_unit and rsa_unit instances.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } const_state_t;

  // mmm_unit carries two guard bits beyond the modulus width.
  function automatic int mmm_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/mod_double_unit.sv
// Combinational modular doubling: r_out = 2*r_in mod m, valid only while r_in < m.
module mod_double_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] diff;

  assign t     = {r_i, 1'b0};
  assign m_ext = {1'b0, m_i};
  assign diff  = t - m_ext;

  // r_i < m_i bounds the result below m_i, so dropping the top bit is lossless.
  always_comb begin
    r_o = t[WIDTH-1:0];
    if (t >= m_ext) begin
      r_o = diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mont_const_unit.sv
// Bit-serial Montgomery constant generator: Const = 2^(2K) mod M, K = WIDTH+2,
// built from 2K modular doublings of 1 so no multiplier or divider is needed.
module mont_const_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] const_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             valid_o,
  output logic             err_o
);

  localparam int K      = mmm_width(WIDTH);
  localparam int ITERS  = 2 * K;
  localparam int CNT_W  = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  const_state_t     state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] const_q;
  logic             done_q;
  logic             valid_q;
  logic             err_q;

  mod_double_unit #(.WIDTH(WIDTH)) u_dbl (
    .r_i (r_q),
    .m_i (m_q),
    .r_o (r_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      const_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      const_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena_i) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            m_q     <= m_i;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= INIT;
          end
        end
        INIT: begin
          // An even modulus (including zero) has no Montgomery inverse.
          if (!m_q[0]) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            r_q     <= (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
            cnt_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          if (err_q) begin
            const_q <= '0;
          end else begin
            const_q <= r_q;
            valid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign const_o = const_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mont_const_unit.sv
// Randomised and directed bench for mont_const_unit against 2^20 mod M.
module tb_mont_const_unit;
  import rsa_pkg::*;

  localparam int WIDTH = 8;
  localparam int LAT_GOOD = 22;
  localparam int LAT_ERR  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b1;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] m = '0;
  logic [WIDTH-1:0] const_v;
  logic             busy, done, valid, err;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  mont_const_unit #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ena_i   (ena),
    .clear_i (clear),
    .start_i (start),
    .m_i     (m),
    .const_o (const_v),
    .busy_o  (busy),
    .done_o  (done),
    .valid_o (valid),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_const(input int unsigned mod);
    longint unsigned p;
    p = 64'd1 << 20;
    return WIDTH'(p % mod);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [WIDTH-1:0] mv);
    m = mv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy !== (dut.state_q != IDLE)) begin
        errors++;
        $display("FAIL busy_state: busy=%b state=%0d", busy, dut.state_q);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (const_v !== '0) begin errors++; $display("FAIL reset_const: got %0d want 0", const_v); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    mon_en = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    logic [WIDTH-1:0] mods [4] = '{8'd251, 8'd255, 8'd3, 8'd1};
    logic [WIDTH-1:0] exps [4] = '{8'd149, 8'd16, 8'd1, 8'd0};
    foreach (mods[i]) begin
      start_pulse(mods[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir_busy M=%0d: got %b want 1", mods[i], busy); end
      wait_done(lat);
      checks++; if (lat != LAT_GOOD) begin errors++; $display("FAIL dir_latency M=%0d: got %0d want %0d", mods[i], lat, LAT_GOOD); end
      checks++; if (const_v !== exps[i]) begin errors++; $display("FAIL dir_const M=%0d: got %0d want %0d", mods[i], const_v, exps[i]); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL dir_valid M=%0d: got %b want 1", mods[i], valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL dir_err M=%0d: got %b want 0", mods[i], err); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir_done_pulse M=%0d: got %b want 0", mods[i], done); end
    end
  endtask

  task automatic test_errors();
    int lat;
    logic [WIDTH-1:0] mods [2] = '{8'd0, 8'd254};
    foreach (mods[i]) begin
      start_pulse(mods[i]);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL err_valid_cleared M=%0d: got %b want 0", mods[i], valid); end
      wait_done(lat);
      checks++; if (lat != LAT_ERR) begin errors++; $display("FAIL err_latency M=%0d: got %0d want %0d", mods[i], lat, LAT_ERR); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag M=%0d: got %b want 1", mods[i], err); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL err_valid M=%0d: got %b want 0", mods[i], valid); end
      checks++; if (const_v !== '0) begin errors++; $display("FAIL err_const M=%0d: got %0d want 0", mods[i], const_v); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_held M=%0d: got %b want 1", mods[i], err); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_pulse(8'd251);
    for (int i = 0; i < 4; i++) tick();
    m = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat + 5 != LAT_GOOD) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat + 5, LAT_GOOD); end
    checks++; if (const_v !== 8'd149) begin errors++; $display("FAIL ignore_const: got %0d want 149", const_v); end
    start_pulse(8'd3);
    wait_done(lat);
    checks++; if (lat != LAT_GOOD) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT_GOOD); end
    checks++; if (const_v !== 8'd1) begin errors++; $display("FAIL b2b_const: got %0d want 1", const_v); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", valid); end
  endtask

  task automatic test_clear();
    int seen;
    start_pulse(8'd251);
    for (int i = 0; i < 9; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b want 0", valid); end
    checks++; if (const_v !== '0) begin errors++; $display("FAIL clear_const: got %0d want 0", const_v); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL clear_no_done: got %0d pulses want 0", seen); end
  endtask

  task automatic test_stall();
    int lat;
    start_pulse(8'd251);
    for (int i = 0; i < 5; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
    ena = 1'b1;
    wait_done(lat);
    checks++; if (lat + 12 != LAT_GOOD + 7) begin errors++; $display("FAIL stall_latency: got %0d want %0d", lat + 12, LAT_GOOD + 7); end
    checks++; if (const_v !== 8'd149) begin errors++; $display("FAIL stall_const: got %0d want 149", const_v); end
  endtask

  task automatic test_random();
    int lat;
    logic [WIDTH-1:0] mv;
    logic [WIDTH-1:0] exp_c;
    for (int n = 0; n < 24; n++) begin
      if (n % 6 == 5) mv = WIDTH'($urandom_range(0, 127) * 2);
      else            mv = WIDTH'($urandom_range(0, 127) * 2 + 1);
      start_pulse(mv);
      wait_done(lat);
      if (mv[0]) begin
        exp_c = ref_const(int'(mv));
        checks++; if (lat != LAT_GOOD) begin errors++; $display("FAIL rnd_latency M=%0d: got %0d want %0d", mv, lat, LAT_GOOD); end
        checks++; if (const_v !== exp_c) begin errors++; $display("FAIL rnd_const M=%0d: got %0d want %0d", mv, const_v, exp_c); end
        checks++; if (valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rnd_flags M=%0d: got valid=%b err=%b want 1/0", mv, valid, err); end
      end else begin
        checks++; if (lat != LAT_ERR) begin errors++; $display("FAIL rnd_err_latency M=%0d: got %0d want %0d", mv, lat, LAT_ERR); end
        checks++; if (err !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL rnd_err_flags M=%0d: got err=%b valid=%b want 1/0", mv, err, valid); end
      end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rnd_done_pulse M=%0d: got %b want 0", mv, done); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_clear();
    test_stall();
    test_random();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
